// File: rtl/dc_motor_pwm_ctrl_pkg.sv
// Shared types and default constants for the multi-channel H-bridge PWM controller.
package dc_motor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DEAD  = 2'd2,
    ST_BRAKE = 2'd3
  } chan_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int DEF_CH        = 2;
  localparam int DEF_CNT_W     = 12;
  localparam int DEF_PRESC_DIV = 256;
  localparam int DEF_PERIOD    = 4000;
  localparam int DEF_RAMP_STEP = 16;
  localparam int DEF_DEAD      = 8;

endpackage

// File: rtl/dc_motor_pwm_ctrl_if.sv
// Front-end / driver-pin bundle of the motor controller.
// master = register front end, slave = the controller itself.
interface dc_motor_pwm_ctrl_if #(
  parameter int CH    = 2,
  parameter int CNT_W = 12
);
  logic                en;
  logic [CH*CNT_W-1:0] duty_tgt;
  logic [CH-1:0]       dir_tgt;
  logic [CH-1:0]       brake;
  logic [CH-1:0]       hb_a;
  logic [CH-1:0]       hb_b;
  logic [CH*CNT_W-1:0] duty_cur;
  logic [CH-1:0]       busy;
  logic                prd_start;

  modport master (
    output en, duty_tgt, dir_tgt, brake,
    input  hb_a, hb_b, duty_cur, busy, prd_start
  );

  modport slave (
    input  en, duty_tgt, dir_tgt, brake,
    output hb_a, hb_b, duty_cur, busy, prd_start
  );
endinterface

// File: rtl/dc_motor_pwm_ctrl_chan.sv
// One motor channel: duty ramp, direction/brake FSM, dead-time counter and PWM compare.
module dc_motor_pwm_chan
  import dc_motor_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int DEAD      = DEF_DEAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             prd_start_i,
  input  logic [CNT_W-1:0] pcnt_i,
  input  logic [CNT_W-1:0] duty_tgt_i,
  input  logic             dir_tgt_i,
  input  logic             brake_i,
  output logic             hb_a_o,
  output logic             hb_b_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] duty_o
);

  localparam int              EW        = CNT_W + 1;
  localparam logic [CNT_W:0]  PERIOD_X  = EW'(PERIOD);
  localparam logic [CNT_W:0]  RAMP_X    = EW'(RAMP_STEP);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  chan_state_e      state_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] deadCnt_q;
  logic             dir_q;
  logic             hbA_q;
  logic             hbB_q;

  logic [CNT_W:0]   eff_d;
  logic [CNT_W:0]   cur_d;
  logic [CNT_W:0]   ramp_d;
  logic [CNT_W-1:0] duty_d;
  logic             pwm;

  // Next ramped duty toward the clamped target (zero while decelerating), one extra bit so nothing wraps.
  always_comb begin
    cur_d = {1'b0, duty_q};
    if (state_q == ST_DECEL)
      eff_d = '0;
    else if ({1'b0, duty_tgt_i} >= PERIOD_X)
      eff_d = PERIOD_X;
    else
      eff_d = {1'b0, duty_tgt_i};

    if (eff_d > cur_d)
      ramp_d = ((eff_d - cur_d) <= RAMP_X) ? eff_d : (cur_d + RAMP_X);
    else
      ramp_d = ((cur_d - eff_d) <= RAMP_X) ? eff_d : (cur_d - RAMP_X);

    duty_d = ramp_d[CNT_W] ? '1 : ramp_d[CNT_W-1:0];
    pwm    = (pcnt_i < duty_q);
  end

  // Channel FSM with registered bridge outputs; enable-low and brake take precedence over the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      duty_q    <= '0;
      deadCnt_q <= '0;
      dir_q     <= DIR_FWD;
      hbA_q     <= 1'b0;
      hbB_q     <= 1'b0;
    end else if (!en_i) begin
      state_q   <= ST_RUN;
      duty_q    <= '0;
      deadCnt_q <= '0;
      dir_q     <= dir_tgt_i;
      hbA_q     <= 1'b0;
      hbB_q     <= 1'b0;
    end else if (brake_i) begin
      state_q   <= ST_BRAKE;
      duty_q    <= '0;
      deadCnt_q <= '0;
      hbA_q     <= 1'b1;
      hbB_q     <= 1'b1;
    end else begin
      hbA_q <= (dir_q == DIR_FWD) && pwm;
      hbB_q <= (dir_q == DIR_REV) && pwm;
      unique case (state_q)
        ST_RUN: begin
          if (prd_start_i) duty_q <= duty_d;
          if (dir_tgt_i != dir_q) state_q <= ST_DECEL;
        end
        ST_DECEL: begin
          if (prd_start_i) begin
            if (duty_q == '0) begin
              state_q   <= ST_DEAD;
              deadCnt_q <= '0;
            end else begin
              duty_q <= duty_d;
            end
          end
        end
        ST_DEAD: begin
          hbA_q <= 1'b0;
          hbB_q <= 1'b0;
          if (tick_i) begin
            if (deadCnt_q == DEAD_LAST) begin
              state_q   <= ST_RUN;
              dir_q     <= dir_tgt_i;
              duty_q    <= '0;
              deadCnt_q <= '0;
            end else begin
              deadCnt_q <= deadCnt_q + CNT_W'(1);
            end
          end
        end
        ST_BRAKE: begin
          state_q <= ST_RUN;
          duty_q  <= '0;
          dir_q   <= dir_tgt_i;
          hbA_q   <= 1'b0;
          hbB_q   <= 1'b0;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign hb_a_o = hbA_q;
  assign hb_b_o = hbB_q;
  assign duty_o = duty_q;
  assign busy_o = (state_q == ST_DECEL) || (state_q == ST_DEAD);

endmodule

// File: rtl/dc_motor_pwm_ctrl.sv
// Multi-channel H-bridge PWM controller: shared prescaler and period counter feeding CH channels.
module dc_motor_pwm_ctrl
  import dc_motor_pkg::*;
#(
  parameter int CH        = DEF_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PRESC_DIV = DEF_PRESC_DIV,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int DEAD      = DEF_DEAD
) (
  input logic                 clk,
  input logic                 rst,
  dc_motor_pwm_ctrl_if.slave  bus
);

  localparam int               PW         = $clog2(PRESC_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [CNT_W-1:0] PCNT_LAST  = CNT_W'(PERIOD - 1);

  logic [PW-1:0]       presc_q;
  logic [CNT_W-1:0]    pcnt_q;
  logic                first_q;
  logic                prdStart_q;
  logic                tick;
  logic                prdStart_d;
  logic [CH-1:0]       hbA;
  logic [CH-1:0]       hbB;
  logic [CH-1:0]       busy;
  logic [CH*CNT_W-1:0] dutyCur;

  assign tick       = bus.en && (presc_q == PRESC_LAST);
  assign prdStart_d = tick && (first_q || (pcnt_q == PCNT_LAST));

  // Prescaler: free-running divide-by-PRESC_DIV while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc_q <= '0;
    else if (!bus.en || tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + PW'(1);
  end

  // Period counter; the first tick after enable restarts the period at zero so every channel sees a clean start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q     <= '0;
      first_q    <= 1'b1;
      prdStart_q <= 1'b0;
    end else if (!bus.en) begin
      pcnt_q     <= '0;
      first_q    <= 1'b1;
      prdStart_q <= 1'b0;
    end else begin
      prdStart_q <= prdStart_d;
      if (tick) begin
        first_q <= 1'b0;
        if (first_q || (pcnt_q == PCNT_LAST))
          pcnt_q <= '0;
        else
          pcnt_q <= pcnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    dc_motor_pwm_chan #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP),
      .DEAD      (DEAD)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en_i        (bus.en),
      .tick_i      (tick),
      .prd_start_i (prdStart_d),
      .pcnt_i      (pcnt_q),
      .duty_tgt_i  (bus.duty_tgt[i*CNT_W +: CNT_W]),
      .dir_tgt_i   (bus.dir_tgt[i]),
      .brake_i     (bus.brake[i]),
      .hb_a_o      (hbA[i]),
      .hb_b_o      (hbB[i]),
      .busy_o      (busy[i]),
      .duty_o      (dutyCur[i*CNT_W +: CNT_W])
    );
  end

  assign bus.hb_a      = hbA;
  assign bus.hb_b      = hbB;
  assign bus.busy      = busy;
  assign bus.duty_cur  = dutyCur;
  assign bus.prd_start = prdStart_q;

endmodule

// File: tb/tb_dc_motor_pwm_ctrl.sv
// Directed bench for dc_motor_pwm_ctrl with CH=2, CNT_W=8, PRESC_DIV=4, PERIOD=100, RAMP_STEP=25, DEAD=3.
module tb_dc_motor_pwm_ctrl;

  localparam int CH        = 2;
  localparam int CNT_W     = 8;
  localparam int PRESC_DIV = 4;
  localparam int PERIOD    = 100;
  localparam int RAMP_STEP = 25;
  localparam int DEAD      = 3;
  localparam int PRD_CLKS  = PRESC_DIV * PERIOD;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dc_motor_pwm_ctrl_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

  dc_motor_pwm_ctrl #(
    .CH        (CH),
    .CNT_W     (CNT_W),
    .PRESC_DIV (PRESC_DIV),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP),
    .DEAD      (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive every front-end input at once.
  task automatic applyStimulus(input logic en, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] dir, input logic [1:0] brk);
    bus.en       = en;
    bus.duty_tgt = {d1, d0};
    bus.dir_tgt  = dir;
    bus.brake    = brk;
  endtask

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // Advance to the next negedge at which prd_start is high, bounded.
  task automatic waitPrd(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.prd_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_prd_found"}, 32'(bus.prd_start), 1);
  endtask

  // Called at a prd_start negedge: check applied duties, then count leg-high clocks over the whole period.
  task automatic checkPeriod(input string tag, input int d0, input int d1, input bit dir0, input bit dir1);
    int hiA0, hiB0, hiA1, hiB1;
    hiA0 = 0; hiB0 = 0; hiA1 = 0; hiB1 = 0;
    checkOutput({tag, "_prd"}, 32'(bus.prd_start), 1);
    checkOutput({tag, "_duty0"}, 32'(bus.duty_cur[7:0]), d0);
    checkOutput({tag, "_duty1"}, 32'(bus.duty_cur[15:8]), d1);
    for (int k = 0; k < PRD_CLKS; k++) begin
      @(negedge clk);
      if (bus.hb_a[0]) hiA0++;
      if (bus.hb_b[0]) hiB0++;
      if (bus.hb_a[1]) hiA1++;
      if (bus.hb_b[1]) hiB1++;
    end
    checkOutput({tag, "_hiA0"}, hiA0, dir0 ? 0 : PRESC_DIV * d0);
    checkOutput({tag, "_hiB0"}, hiB0, dir0 ? PRESC_DIV * d0 : 0);
    checkOutput({tag, "_hiA1"}, hiA1, dir1 ? 0 : PRESC_DIV * d1);
    checkOutput({tag, "_hiB1"}, hiB1, dir1 ? PRESC_DIV * d1 : 0);
  endtask

  initial begin
    int n;
    int legs;
    int viol;

    // Reset with enable low so each channel takes its requested direction before running.
    rst = 1'b1;
    applyStimulus(1'b0, 8'd60, 8'd30, 2'b10, 2'b00);
    #23;
    checkOutput("rst_hb_a", 32'(bus.hb_a), 0);
    checkOutput("rst_hb_b", 32'(bus.hb_b), 0);
    checkOutput("rst_duty", 32'(bus.duty_cur), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_prd", 32'(bus.prd_start), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b10, 2'b00);

    // Soft start: ch0 fwd to 60, ch1 rev to 30.
    waitPrd("sync");
    checkPeriod("ss1", 25, 25, 0, 1);
    checkPeriod("ss2", 50, 30, 0, 1);
    checkPeriod("ss3", 60, 30, 0, 1);

    // Over-range target clamps to full period, then ramp down to zero.
    applyStimulus(1'b1, 8'd255, 8'd30, 2'b10, 2'b00);
    checkPeriod("ss4", 60, 30, 0, 1);
    checkPeriod("clamp85", 85, 30, 0, 1);
    checkPeriod("clamp100", 100, 30, 0, 1);
    applyStimulus(1'b1, 8'd0, 8'd30, 2'b10, 2'b00);
    checkPeriod("full", 100, 30, 0, 1);
    checkPeriod("down75", 75, 30, 0, 1);
    checkPeriod("down50", 50, 30, 0, 1);
    checkPeriod("down25", 25, 30, 0, 1);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b10, 2'b00);
    checkPeriod("zero", 0, 30, 0, 1);
    checkPeriod("up25", 25, 30, 0, 1);
    checkPeriod("up50", 50, 30, 0, 1);
    checkPeriod("steady60", 60, 30, 0, 1);

    // Reversal of ch0: decel on the old leg, dead time, then ramp on leg B.
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b11, 2'b00);
    @(negedge clk);
    checkOutput("rev_busy", 32'(bus.busy[0]), 1);
    waitPrd("rev");
    checkPeriod("dec35", 35, 30, 0, 1);
    checkPeriod("dec10", 10, 30, 0, 1);
    checkPeriod("dec0", 0, 30, 0, 1);
    n = 0;
    legs = 0;
    while (bus.busy[0] === 1'b1 && n < 100) begin
      n++;
      if (bus.hb_a[0] || bus.hb_b[0]) legs++;
      @(negedge clk);
    end
    checkOutput("dead_len", n, PRESC_DIV * DEAD);
    checkOutput("dead_legs", legs, 0);
    waitPrd("rup");
    checkPeriod("rup25", 25, 30, 1, 1);
    checkPeriod("rup50", 50, 30, 1, 1);
    checkPeriod("rup60", 60, 30, 1, 1);
    checkOutput("rup_busy", 32'(bus.busy), 0);

    // Brake ch0 mid-period, request fwd while braked, release.
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b11, 2'b01);
    @(negedge clk);
    checkOutput("brk_a", 32'(bus.hb_a[0]), 1);
    checkOutput("brk_b", 32'(bus.hb_b[0]), 1);
    checkOutput("brk_duty0", 32'(bus.duty_cur[7:0]), 0);
    checkOutput("brk_duty1", 32'(bus.duty_cur[15:8]), 30);
    checkOutput("brk_busy", 32'(bus.busy[0]), 0);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b10, 2'b01);
    repeat (50) @(negedge clk);
    checkOutput("brk_hold_ab", {30'd0, bus.hb_a[0], bus.hb_b[0]}, 3);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b10, 2'b00);
    @(negedge clk);
    checkOutput("rel_ab", {30'd0, bus.hb_a[0], bus.hb_b[0]}, 0);
    checkOutput("rel_duty0", 32'(bus.duty_cur[7:0]), 0);
    checkOutput("rel_busy", 32'(bus.busy[0]), 0);
    waitPrd("brk");
    checkPeriod("brk25", 25, 30, 0, 1);

    // Reverse ch1 into dead time, then async reset while ch0 drives.
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b00, 2'b00);
    checkPeriod("r5a", 50, 30, 0, 1);
    checkPeriod("r5b", 60, 5, 0, 1);
    checkPeriod("r5c", 60, 0, 0, 1);
    checkOutput("ch1_dead", 32'(bus.busy[1]), 1);
    repeat (5) @(negedge clk);
    checkOutput("ch1_dead_mid", 32'(bus.busy[1]), 1);
    checkOutput("ch0_on", 32'(bus.hb_a[0]), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_hb_a", 32'(bus.hb_a), 0);
    checkOutput("arst_hb_b", 32'(bus.hb_b), 0);
    checkOutput("arst_duty", 32'(bus.duty_cur), 0);
    checkOutput("arst_busy", 32'(bus.busy), 0);
    checkOutput("arst_prd", 32'(bus.prd_start), 0);
    @(negedge clk);
    rst = 1'b0;
    waitPrd("post_rst");
    checkPeriod("post25", 25, 25, 0, 0);

    // Enable low for 50 clocks, then restart.
    repeat (100) @(negedge clk);
    applyStimulus(1'b0, 8'd60, 8'd30, 2'b00, 2'b00);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.hb_a != 0 || bus.hb_b != 0 || bus.duty_cur != 0 || bus.busy != 0 || bus.prd_start != 0)
        viol++;
    end
    checkOutput("en_low_idle", viol, 0);
    applyStimulus(1'b1, 8'd60, 8'd30, 2'b00, 2'b00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.prd_start !== 1'b1 && n < 1000);
    checkOutput("en_first_tick", n, PRESC_DIV);
    checkPeriod("en25", 25, 25, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
